// File: rtl/serial_frame_rx_if.sv
// ============================================================================
// Module   : serial_frame_rx_if
// Purpose  : Serial line and parallel result bundle for serial_frame_rx.
// Revision : 1.0
// ============================================================================
`default_nettype none

interface serial_frame_rx_if #(
  parameter int WIDTH = 8
);
  logic             D;
  logic [WIDTH-1:0] Q;
  logic             V;
  logic             E;
  logic             BUSY;

  modport master (output D, input Q, V, E, BUSY);
  modport slave  (input D, output Q, V, E, BUSY);
endinterface

`default_nettype wire

// File: rtl/serial_frame_rx.sv
// ============================================================================
// Module   : serial_frame_rx
// Purpose  : Start/data/stop frame receiver, one sample per rising C edge.
//            Optional even-parity bit: define SERIAL_FRAME_RX_PARITY_EN.
// Revision : 1.0
// ============================================================================
`default_nettype none

module serial_frame_rx #(
  parameter int WIDTH     = 8,
  parameter int STOP_BITS = 1
) (
  input  wire             C,
  input  wire             nR,
  serial_frame_rx_if.slave bus
);

  localparam int CW = $clog2(WIDTH) + 1;

`ifdef SERIAL_FRAME_RX_PARITY_EN
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_BREAK, S_PARITY
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_STOP, S_BREAK
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] sr_q, sr_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             v_q, v_d;
  logic             e_q, e_d;
  logic             stop_bad_q, stop_bad_d;
  logic             stop_bad_now;
  logic             frame_bad;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  logic             par_q, par_d;
  logic             perr_q, perr_d;
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    sr_d         = sr_q;
    q_d          = q_q;
    v_d          = 1'b0;
    e_d          = 1'b0;
    stop_bad_d   = stop_bad_q;
    stop_bad_now = stop_bad_q | ~bus.D;
    frame_bad    = stop_bad_now;
`ifdef SERIAL_FRAME_RX_PARITY_EN
    par_d        = par_q;
    perr_d       = perr_q;
    frame_bad    = stop_bad_now | perr_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (!bus.D) begin
          state_d    = S_START;
          cnt_d      = '0;
          stop_bad_d = 1'b0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
          par_d      = 1'b0;
          perr_d     = 1'b0;
`endif
        end
      end

      // The start bit was the sample that entered this state; this edge is spent.
      S_START: begin
        state_d = S_DATA;
        cnt_d   = '0;
      end

      S_DATA: begin
        for (int i = 0; i < WIDTH; i++) begin
          if (cnt_q == CW'(i)) sr_d[i] = bus.D;
        end
`ifdef SERIAL_FRAME_RX_PARITY_EN
        par_d = par_q ^ bus.D;
`endif
        if (cnt_q == CW'(WIDTH - 1)) begin
          cnt_d = '0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
          state_d = S_PARITY;
`else
          state_d = S_STOP;
`endif
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end

`ifdef SERIAL_FRAME_RX_PARITY_EN
      S_PARITY: begin
        perr_d  = par_q ^ bus.D;
        state_d = S_STOP;
      end
`endif

      // Every stop bit is sampled before the verdict so frame length is fixed.
      S_STOP: begin
        if (cnt_q == CW'(STOP_BITS - 1)) begin
          cnt_d = '0;
          if (frame_bad) begin
            e_d     = 1'b1;
            state_d = stop_bad_now ? S_BREAK : S_IDLE;
          end else begin
            v_d     = 1'b1;
            q_d     = sr_q;
            state_d = S_IDLE;
          end
        end else begin
          stop_bad_d = stop_bad_now;
          cnt_d      = cnt_q + CW'(1);
        end
      end

      S_BREAK: begin
        if (bus.D) state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge C or negedge nR) begin
    if (!nR) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      sr_q       <= '0;
      q_q        <= '0;
      v_q        <= 1'b0;
      e_q        <= 1'b0;
      stop_bad_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sr_q       <= sr_d;
      q_q        <= q_d;
      v_q        <= v_d;
      e_q        <= e_d;
      stop_bad_q <= stop_bad_d;
    end
  end

`ifdef SERIAL_FRAME_RX_PARITY_EN
  always_ff @(posedge C or negedge nR) begin
    if (!nR) begin
      par_q  <= 1'b0;
      perr_q <= 1'b0;
    end else begin
      par_q  <= par_d;
      perr_q <= perr_d;
    end
  end
`endif

  assign bus.Q    = q_q;
  assign bus.V    = v_q;
  assign bus.E    = e_q;
  assign bus.BUSY = (state_q != S_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_serial_frame_rx.sv
// ============================================================================
// Module   : tb_serial_frame_rx
// Purpose  : Randomized frame stream against a frame-level timeline model.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_serial_frame_rx;

  localparam int WIDTH     = 8;
  localparam int STOP_BITS = 1;
`ifdef SERIAL_FRAME_RX_PARITY_EN
  localparam int PAR_BITS  = 1;
`else
  localparam int PAR_BITS  = 0;
`endif

  typedef struct {
    logic        d;
    logic        v;
    logic        e;
    logic [15:0] q;
    logic        busy;
  } step_t;

  logic        C  = 1'b0;
  logic        nR = 1'b0;
  step_t       seq[$];
  logic [15:0] model_q;
  logic [15:0] mask;
  int          total = 0;
  int          bad   = 0;

  serial_frame_rx_if #(.WIDTH(WIDTH)) bus ();

  serial_frame_rx #(.WIDTH(WIDTH), .STOP_BITS(STOP_BITS)) dut (
    .C   (C),
    .nR  (nR),
    .bus (bus)
  );

  always #5 C = ~C;

  task automatic chk(input string tag, input int unsigned got, input int unsigned exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push_step(input logic d, input logic v, input logic e, input logic busy);
    step_t s;
    s.d = d; s.v = v; s.e = e; s.q = model_q; s.busy = busy;
    seq.push_back(s);
  endtask

  // Expected timeline of one frame: each entry is the line level driven before
  // an edge and the outputs expected just after that edge.
  task automatic add_frame(input int gap, input logic [15:0] data, input logic [1:0] stop,
                           input bit par_flip, input int zeros);
    logic [15:0] dm;
    logic        stop_ok;
    logic        good;
    dm      = data & mask;
    stop_ok = 1'b1;
    for (int j = 0; j < STOP_BITS; j++) if (!stop[j]) stop_ok = 1'b0;
    good = stop_ok && !(PAR_BITS == 1 && par_flip);
    for (int g = 0; g < gap; g++) push_step(1'b1, 1'b0, 1'b0, 1'b0);
    push_step(1'b0, 1'b0, 1'b0, 1'b1);
    push_step(1'($urandom_range(0, 1)), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < WIDTH; i++) push_step(dm[i], 1'b0, 1'b0, 1'b1);
    if (PAR_BITS == 1) push_step((^dm) ^ par_flip, 1'b0, 1'b0, 1'b1);
    for (int j = 0; j < STOP_BITS - 1; j++) push_step(stop[j], 1'b0, 1'b0, 1'b1);
    if (good) model_q = dm;
    push_step(stop[STOP_BITS-1], good, !good, !stop_ok);
    if (!stop_ok) begin
      for (int z = 0; z < zeros; z++) push_step(1'b0, 1'b0, 1'b0, 1'b1);
      push_step(1'b1, 1'b0, 1'b0, 1'b0);
    end
  endtask

  task automatic run_seq();
    step_t s;
    while (seq.size() > 0) begin
      s = seq.pop_front();
      @(negedge C);
      bus.D = s.d;
      @(posedge C);
      #1;
      chk("V",    bus.V,    s.v);
      chk("E",    bus.E,    s.e);
      chk("Q",    bus.Q,    s.q);
      chk("BUSY", bus.BUSY, s.busy);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_Q"},    bus.Q,    0);
    chk({tag, "_V"},    bus.V,    0);
    chk({tag, "_E"},    bus.E,    0);
    chk({tag, "_BUSY"}, bus.BUSY, 0);
  endtask

  initial begin
    logic [1:0] stop;
    bit         pf;
    mask    = 16'((32'd1 << WIDTH) - 1);
    model_q = '0;
    bus.D   = 1'b1;
    #1;
    chk_reset_outputs("rst_async");

    for (int i = 0; i < 3; i++) begin
      @(negedge C);
      bus.D = i[0];
      @(posedge C);
      #1;
      chk_reset_outputs("rst_hold");
    end
    @(negedge C);
    bus.D = 1'b1;
    nR    = 1'b1;
    push_step(1'b1, 1'b0, 1'b0, 1'b0);
    push_step(1'b1, 1'b0, 1'b0, 1'b0);

    add_frame(1, 16'hA5, 2'b11, 1'b0, 0);
    add_frame(2, 16'h3C, 2'b11, 1'b0, 0);
    add_frame(0, 16'hC3, 2'b11, 1'b0, 0);
    add_frame(1, 16'h5A, 2'b00, 1'b0, 5);
    if (PAR_BITS == 1) begin
      add_frame(1, 16'h07, 2'b11, 1'b0, 0);
      add_frame(1, 16'h07, 2'b11, 1'b1, 0);
    end
    for (int n = 0; n < 40; n++) begin
      stop = 2'b11;
      if ($urandom_range(0, 4) == 0) stop[$urandom_range(0, STOP_BITS - 1)] = 1'b0;
      pf = (PAR_BITS == 1) && ($urandom_range(0, 4) == 0);
      add_frame($urandom_range(0, 2), 16'($urandom), stop, pf, $urandom_range(0, 4));
    end
    add_frame(1, 16'h66, 2'b11, 1'b0, 0);
    run_seq();

    // Abort a frame of all ones after four data bits.
    push_step(1'b0, 1'b0, 1'b0, 1'b1);
    push_step(1'b1, 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) push_step(1'b1, 1'b0, 1'b0, 1'b1);
    run_seq();
    @(negedge C);
    #1;
    nR = 1'b0;
    #1;
    chk_reset_outputs("rst_mid");
    model_q = '0;
    @(negedge C);
    bus.D = 1'b1;
    nR    = 1'b1;
    add_frame(1, 16'h81, 2'b11, 1'b0, 0);
    push_step(1'b1, 1'b0, 1'b0, 1'b0);
    run_seq();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
